led_show_ctrl: RTL and testbench
================================

Name: led_show_ctrl

Overview:
- Controller/sequencer for the 8-bit flowing-water LED display.
- Takes four raw push-buttons (run/pause, stop, mode, speed), debounces them and runs an IDLE/RUN/PAUSE state machine.
- Generates the step tick from a selectable period and advances the LED pattern, one of four, on each tick.
- Sits between the board buttons and the LED pins.

Parameters:
- DEB_CYCLES, 1_000_000: clock cycles a raw button level must stay stable to be accepted.
- TICK_0, 10_000_000: step period in cycles, speed 0.
- TICK_1, 20_000_000: step period, speed 1.
- TICK_2, 50_000_000: step period, speed 2.
- TICK_3, 100_000_000: step period, speed 3.
- CNT_W, 27: width of the tick counter; must hold TICK_3-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_run  in  1  raw run/pause button, active-high, asynchronous to clk
- btn_stop  in  1  raw stop button, active-high
- btn_mode  in  1  raw pattern-select button, active-high
- btn_speed  in  1  raw speed-select button, active-high
- led  out  8  LED drive, bit0 = rightmost
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE
- mode  out  2  current pattern
- speed  out  2  current speed index

Behaviour:
- Reset (rst_n low, async): state=IDLE, mode=0, speed=0, led=8'h01, tick counter=0, debounced levels=0, all sync flops=0.
- Debounce, per button:
  - 2-flop synchronizer, then a stability counter. The debounced level takes the synced value after DEB_CYCLES consecutive equal samples that differ from the current debounced level.
  - Any mismatch clears the counter.
  - Press event = one-cycle pulse on the debounced 0->1 edge. Release generates nothing.
  - Latency from a clean raw edge to the pulse is DEB_CYCLES+2 or DEB_CYCLES+3 cycles.
- FSM:
  - IDLE: run press -> RUN. Counter held at 0, led holds.
  - RUN: run press -> PAUSE. Stop press -> IDLE.
  - PAUSE: run press -> RUN. Stop press -> IDLE. Counter and led frozen; RUN resumes from the frozen count.
  - Stop always reloads led with the current mode seed and clears the counter.
  - Stop in IDLE reseeds only.
  - Stop wins over run in the same cycle.
- Tick counter, RUN only:
  - Counts 0..P-1, where P = TICK_<speed>.
  - When cnt==P-1: one-cycle tick, cnt<=0, led advances on the same edge.
  - Step period is exactly P cycles. First step comes P cycles after entering RUN from IDLE.
- Speed press, any state: speed <= speed+1 mod 4 (3 wraps to 0); cnt<=0; led unchanged.
- Mode press, any state: mode <= mode+1 mod 4; led <= new mode's seed; cnt<=0; ping-pong direction <= left. State unchanged.
- Patterns, applied on each tick:
  - mode0: rotate left, seed 8'h01. 01,02,..,80,01.
  - mode1: rotate right, seed 8'h80. 80,40,..,01,80.
  - mode2: ping-pong, seed 8'h01, direction starts left.
    - Shift in the current direction.
    - Reverse when the led value after the shift is 8'h80 (now going right) or 8'h01 (now going left).
    - Sequence: 01,02,..,80,40,..,01,02. End values show for one period each, never repeated.
  - mode3: blink, seed 8'h0F; each tick led <= ~led (0F,F0,0F).
- Simultaneous events in one cycle:
  - Mode and speed presses both apply.
  - A mode press coinciding with a tick: the seed load wins and the tick is discarded.
  - A run press coinciding with a tick: the tick applies (led advances), then state changes.
- Reset mid-operation returns everything to reset values immediately, regardless of button levels.
- Glitches shorter than DEB_CYCLES never produce events.

Test Plan (DEB_CYCLES=4, TICK_0..3 = 8,16,32,64):
- Reset, press run (held 10 cycles) -> state=01; led goes 01 -> 02 -> 04, one step every 8 cycles; after 8 steps led=01 again.
- Running mode0, press run -> state=10; led stays frozen over 100 cycles. Press run again -> next step exactly (8 - frozen count) cycles later.
- Press mode twice (mode=2) while running -> led=01 at once. Ticks give 01,02,..,80,40,..,01,02; 80 and 01 each last 8 cycles only.
- Press speed three times -> speed=3, step period 64 cycles. Fourth press -> speed=0, period 8.
- Glitch btn_mode high for 3 cycles -> no mode change. Press stop in PAUSE with mode3 -> state=00, led=0F.
- Assert rst_n low mid-RUN with mode=1, speed=2 -> immediately led=01, mode=0, speed=0, state=00.

Source files
------------

// File: rtl/led_show_ctrl.sv
// ---------------------------------------------------------------------------
// led_show_ctrl
//
// Controller for an 8-bit flowing-water LED display. Four raw push-buttons
// are synchronised, debounced and turned into one-cycle press events. These
// events drive an IDLE/RUN/PAUSE state machine plus mode and speed selectors.
// While running, a tick counter with a selectable period advances one of
// four LED patterns on every tick.
//
// Ports
//   clk        in   1  system clock
//   rst_n      in   1  asynchronous active-low reset
//   btn_run    in   1  raw run/pause button, active-high, asynchronous
//   btn_stop   in   1  raw stop button, active-high, asynchronous
//   btn_mode   in   1  raw pattern-select button, active-high, asynchronous
//   btn_speed  in   1  raw speed-select button, active-high, asynchronous
//   led        out  8  LED drive, bit0 = rightmost
//   state      out  2  00 IDLE, 01 RUN, 10 PAUSE
//   mode       out  2  current pattern (0 rotl, 1 rotr, 2 ping-pong, 3 blink)
//   speed      out  2  current speed index selecting TICK_0..TICK_3
// ---------------------------------------------------------------------------
module led_show_ctrl #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int TICK_0     = 10_000_000,
    parameter int TICK_1     = 20_000_000,
    parameter int TICK_2     = 50_000_000,
    parameter int TICK_3     = 100_000_000,
    parameter int CNT_W      = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_run,
    input  logic       btn_stop,
    input  logic       btn_mode,
    input  logic       btn_speed,
    output logic [7:0] led,
    output logic [1:0] state,
    output logic [1:0] mode,
    output logic [1:0] speed
);

    // The stability counter only ever has to reach DEB_CYCLES-1.
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    localparam logic [CNT_W-1:0] LAST_0 = CNT_W'(TICK_0 - 1);
    localparam logic [CNT_W-1:0] LAST_1 = CNT_W'(TICK_1 - 1);
    localparam logic [CNT_W-1:0] LAST_2 = CNT_W'(TICK_2 - 1);
    localparam logic [CNT_W-1:0] LAST_3 = CNT_W'(TICK_3 - 1);

    // Button index: 0 run, 1 stop, 2 mode, 3 speed.
    localparam int B_RUN   = 0;
    localparam int B_STOP  = 1;
    localparam int B_MODE  = 2;
    localparam int B_SPEED = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------

    // Last count value of a step period for the given speed index.
    function automatic logic [CNT_W-1:0] tick_last(input logic [1:0] s);
        logic [CNT_W-1:0] r;
        case (s)
            2'd0:    r = LAST_0;
            2'd1:    r = LAST_1;
            2'd2:    r = LAST_2;
            default: r = LAST_3;
        endcase
        return r;
    endfunction

    // LED value loaded when a pattern (re)starts.
    function automatic logic [7:0] mode_seed(input logic [1:0] m);
        logic [7:0] r;
        case (m)
            2'd0:    r = 8'h01;
            2'd1:    r = 8'h80;
            2'd2:    r = 8'h01;
            default: r = 8'h0F;
        endcase
        return r;
    endfunction

    // LED value after one step of the given pattern.
    function automatic logic [7:0] pattern_step(input logic [1:0] m,
                                                input logic [7:0] l,
                                                input logic       go_left);
        logic [7:0] r;
        case (m)
            2'd0:    r = {l[6:0], l[7]};
            2'd1:    r = {l[0], l[7:1]};
            2'd2:    r = go_left ? {l[6:0], 1'b0} : {1'b0, l[7:1]};
            default: r = ~l;
        endcase
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Signals
    // -----------------------------------------------------------------------
    logic [3:0]       btn_raw;
    logic [3:0]       sync_p0;
    logic [3:0]       sync_p1;
    logic [3:0]       deb_lvl;
    logic [3:0]       press;
    logic [DEB_W-1:0] deb_cnt [4];

    logic run_p;
    logic stop_p;
    logic mode_p;
    logic speed_p;

    state_t cur_state;
    state_t nxt_state;
    logic   run_en;
    logic   in_idle;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_last;
    logic             tick;
    logic [7:0]       led_q;
    logic [7:0]       led_step;
    logic             go_left;
    logic [1:0]       mode_q;
    logic [1:0]       mode_nxt;
    logic [1:0]       speed_q;

    assign btn_raw = {btn_speed, btn_mode, btn_stop, btn_run};

    // -----------------------------------------------------------------------
    // Stage p0/p1: two-flop synchroniser for the asynchronous buttons
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 4'b0000;
            sync_p1 <= 4'b0000;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // -----------------------------------------------------------------------
    // Debounce: accept a new level after DEB_CYCLES consecutive differing
    // samples. The press pulse is registered on the same edge the level
    // rises, so the FSM sees it one cycle later for exactly one cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_lvl <= 4'b0000;
            press   <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_p1[i] != deb_lvl[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb_lvl[i] <= sync_p1[i];
                        deb_cnt[i] <= '0;
                        press[i]   <= sync_p1[i];
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                        press[i]   <= 1'b0;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                    press[i]   <= 1'b0;
                end
            end
        end
    end

    assign run_p   = press[B_RUN];
    assign stop_p  = press[B_STOP];
    assign mode_p  = press[B_MODE];
    assign speed_p = press[B_SPEED];

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // FSM: next state. Stop has priority over run in the same cycle.
    always_comb begin
        nxt_state = cur_state;
        if (stop_p) begin
            nxt_state = S_IDLE;
        end else if (run_p) begin
            case (cur_state)
                S_IDLE:  nxt_state = S_RUN;
                S_RUN:   nxt_state = S_PAUSE;
                S_PAUSE: nxt_state = S_RUN;
                default: nxt_state = S_IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        run_en  = 1'b0;
        in_idle = 1'b0;
        case (cur_state)
            S_RUN:   run_en  = 1'b1;
            S_PAUSE: run_en  = 1'b0;
            default: in_idle = 1'b1;
        endcase
    end

    // -----------------------------------------------------------------------
    // Tick generation and pattern datapath
    // -----------------------------------------------------------------------
    assign cnt_last = tick_last(speed_q);
    assign tick     = run_en && (cnt == cnt_last);
    assign led_step = pattern_step(mode_q, led_q, go_left);
    assign mode_nxt = mode_p ? (mode_q + 2'd1) : mode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= 2'd0;
            speed_q <= 2'd0;
        end else begin
            mode_q <= mode_nxt;
            if (speed_p) begin
                speed_q <= speed_q + 2'd1;
            end
        end
    end

    // Any seed load (stop or mode press) overrides a coincident tick. A
    // speed press restarts the period but still lets a coincident tick land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q   <= 8'h01;
            go_left <= 1'b1;
        end else if (stop_p || mode_p) begin
            led_q   <= mode_seed(mode_nxt);
            go_left <= 1'b1;
        end else if (tick) begin
            led_q <= led_step;
            // Ping-pong turns around on the end value it just reached, so
            // each end is shown for a single period.
            if (mode_q == 2'd2) begin
                if (led_step == 8'h80) begin
                    go_left <= 1'b0;
                end else if (led_step == 8'h01) begin
                    go_left <= 1'b1;
                end
            end
        end
    end

    // Counter runs only in RUN; PAUSE freezes it so RUN resumes mid-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (stop_p || mode_p || speed_p || in_idle) begin
            cnt <= '0;
        end else if (run_en) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

    assign led   = led_q;
    assign state = cur_state;
    assign mode  = mode_q;
    assign speed = speed_q;

endmodule

// File: tb/tb_led_show_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_show_ctrl
//
// Self-checking bench for led_show_ctrl with short debounce and tick
// periods. A behavioural model tracks raw button history, the resulting
// press events, the run state, and the number of pattern steps since the
// last seed load. The expected LED value is computed directly from
// (mode, step count). Directed scenarios are followed by random button
// activity, and every cycle is checked against the model.
// ---------------------------------------------------------------------------
module tb_led_show_ctrl;

    localparam int DEB = 4;
    localparam int T0  = 8;
    localparam int T1  = 16;
    localparam int T2  = 32;
    localparam int T3  = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btns = 4'b0000;    // 0 run, 1 stop, 2 mode, 3 speed
    logic [7:0] led;
    logic [1:0] state;
    logic [1:0] mode;
    logic [1:0] speed;

    always #5 clk = ~clk;

    led_show_ctrl #(
        .DEB_CYCLES (DEB),
        .TICK_0     (T0),
        .TICK_1     (T1),
        .TICK_2     (T2),
        .TICK_3     (T3),
        .CNT_W      (27)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_run   (btns[0]),
        .btn_stop  (btns[1]),
        .btn_mode  (btns[2]),
        .btn_speed (btns[3]),
        .led       (led),
        .state     (state),
        .mode      (mode),
        .speed     (speed)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_hist [4];   // bit k = raw level sampled k edges ago
    logic [3:0]  m_lvl;
    logic [3:0]  m_pend;
    int          m_st;         // 0 idle, 1 run, 2 pause
    int          m_mode;
    int          m_speed;
    int          m_step;       // ticks since the last seed load
    int          m_phase;      // RUN cycles elapsed in the current period

    function automatic int period(input int s);
        case (s)
            0:       return T0;
            1:       return T1;
            2:       return T2;
            default: return T3;
        endcase
    endfunction

    function automatic logic [7:0] pattern(input int m, input int k);
        logic [7:0] v;
        int p;
        int idx;
        case (m)
            0: begin v = 8'h01; v = v << (k % 8); end
            1: begin v = 8'h80; v = v >> (k % 8); end
            2: begin
                p   = k % 14;
                idx = (p <= 7) ? p : 14 - p;
                v   = 8'h01;
                v   = v << idx;
            end
            default: v = ((k % 2) == 0) ? 8'h0F : 8'hF0;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_hist[i] = 16'h0000;
        m_lvl   = 4'b0000;
        m_pend  = 4'b0000;
        m_st    = 0;
        m_mode  = 0;
        m_speed = 0;
        m_step  = 0;
        m_phase = 0;
    endtask

    // One rising clock edge with the given raw button levels.
    task automatic model_edge(input logic [3:0] raw);
        logic [3:0] ev;
        logic       all_diff;
        logic       tk;
        ev = m_pend;
        for (int i = 0; i < 4; i++) begin
            m_hist[i] = {m_hist[i][14:0], raw[i]};
            // Samples reaching the debouncer are two edges old.
            all_diff = 1'b1;
            for (int k = 2; k <= DEB + 1; k++)
                if (m_hist[i][k] == m_lvl[i]) all_diff = 1'b0;
            m_pend[i] = 1'b0;
            if (all_diff) begin
                m_lvl[i]  = ~m_lvl[i];
                m_pend[i] = m_lvl[i];
            end
        end
        tk = (m_st == 1) && (m_phase == period(m_speed) - 1);
        if (ev[1] || ev[2]) m_step = 0;
        else if (tk)        m_step++;
        if (ev[1] || ev[2] || ev[3]) m_phase = 0;
        else if (m_st == 1)          m_phase = tk ? 0 : m_phase + 1;
        if (ev[2]) m_mode  = (m_mode + 1) % 4;
        if (ev[3]) m_speed = (m_speed + 1) % 4;
        if (ev[1])      m_st = 0;
        else if (ev[0]) m_st = (m_st == 1) ? 2 : 1;
    endtask

    task automatic compare_all();
        check("led",   {24'd0, led},   {24'd0, pattern(m_mode, m_step)});
        check("state", {30'd0, state}, m_st);
        check("mode",  {30'd0, mode},  m_mode);
        check("speed", {30'd0, speed}, m_speed);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge(btns);
        #1;
        compare_all();
    endtask

    task automatic run_cycles(input int n);
        repeat (n) cycle();
    endtask

    task automatic hold(input logic [3:0] mask, input int len, input int gap);
        btns = mask;
        run_cycles(len);
        btns = 4'b0000;
        run_cycles(gap);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_led",   {24'd0, led},   32'h01);
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_mode",  {30'd0, mode},  32'd0);
        check("rst_speed", {30'd0, speed}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();
        run_cycles(3);

        // Start in mode0 and watch a full rotation.
        hold(4'b0001, 10, 2);
        check("run_state", {30'd0, state}, 32'd1);
        run_cycles(80);

        // Pause, stay frozen, then resume mid-period.
        hold(4'b0001, 6, 4);
        check("pause_state", {30'd0, state}, 32'd2);
        run_cycles(100);
        hold(4'b0001, 6, 4);
        check("resume_state", {30'd0, state}, 32'd1);
        run_cycles(40);

        // Two mode presses reach the ping-pong pattern.
        hold(4'b0100, 6, 10);
        hold(4'b0100, 6, 10);
        check("mode2", {30'd0, mode}, 32'd2);
        run_cycles(130);

        // Speed wrap: three presses to speed 3, fourth wraps to 0.
        hold(4'b1000, 6, 10);
        hold(4'b1000, 6, 10);
        hold(4'b1000, 6, 10);
        check("speed3", {30'd0, speed}, 32'd3);
        run_cycles(200);
        hold(4'b1000, 6, 10);
        check("speed0", {30'd0, speed}, 32'd0);
        run_cycles(40);

        // A glitch shorter than the debounce window is ignored.
        hold(4'b0100, 3, 12);
        check("glitch_mode", {30'd0, mode}, 32'd2);

        // Mode3, pause, then stop reseeds with the blink seed.
        hold(4'b0100, 6, 10);
        hold(4'b0001, 6, 10);
        check("pause2", {30'd0, state}, 32'd2);
        hold(4'b0010, 6, 10);
        check("stop_state", {30'd0, state}, 32'd0);
        check("stop_led",   {24'd0, led},   32'h0F);

        // Mode1, speed2, running; reset with run held high.
        hold(4'b0100, 6, 10);
        hold(4'b0100, 6, 10);
        hold(4'b1000, 6, 10);
        hold(4'b1000, 6, 10);
        hold(4'b0001, 6, 10);
        check("pre_rst_mode", {30'd0, mode}, 32'd1);
        run_cycles(100);
        btns = 4'b0001;
        do_reset();
        btns = 4'b0000;
        run_cycles(20);

        // Random button activity, including glitches, overlaps and resets.
        for (int it = 0; it < 300; it++) begin
            int r;
            logic [3:0] mask;
            int len;
            int gap;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                do_reset();
                run_cycles(5);
            end else begin
                if (r < 40)      mask = 4'b0001;
                else if (r < 50) mask = 4'b0010;
                else if (r < 70) mask = 4'b0100;
                else if (r < 88) mask = 4'b1000;
                else             mask = 4'($urandom_range(1, 15));
                len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                  : int'($urandom_range(5, 12));
                gap = int'($urandom_range(0, 70));
                hold(mask, len, gap);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
